jump_motion_ctrl: RTL and testbench
===================================

# jump_motion_ctrl

Per-fighter jump sequencer and hitbox mapper. It sits directly upstream of the per-frame jump sprite renderers. Once per video frame it advances a vertical jump trajectory and selects the animation frame index. Every pixel clock it converts the screen coordinates DrawX/DrawY into hitbox-relative sprite coordinates, with horizontal mirroring applied. The downstream renderer only scales those coordinates into its ROM and needs no position or mirroring logic of its own.

## Interface
- HIT_W, 80, hitbox width in pixels
- HIT_H, 160, hitbox height in pixels
- GROUND_Y, 280, resting hitbox top y
- JUMP_V0, 12, initial upward velocity (px/frame)
- GRAVITY, 1, velocity change per frame
- FRAME_HOLD, 4, frame ticks per animation frame while airborne
- LAND_FRAMES, 6, frame ticks spent in LANDING
- NUM_FRAMES, 7, animation frames (indices 0..6)

Ports:
- vga_clk  in  1  pixel clock; the only clock
- Reset  in  1  synchronous, active-high
- frame_start  in  1  one-cycle pulse per video frame (start of vblank)
- jump_req  in  1  level jump request
- facing_left  in  1  mirror sprite horizontally
- char_x  in  10  hitbox left x (screen)
- DrawX, DrawY  in  10 each  current pixel
- char_y  out  10  hitbox top y
- frame_idx  out  3  animation frame select
- jumping  out  1  high in any state other than IDLE
- in_hitbox  out  1  registered: pixel lies inside hitbox
- sprite_x  out  7  hitbox-relative x, mirrored if facing_left
- sprite_y  out  8  hitbox-relative y

## Operation
- States: IDLE, RISING, FALLING, LANDING. Register vy is 5-bit unsigned.
- All trajectory and state updates occur only on cycles with frame_start=1. No other cycle changes char_y, vy, state or frame_idx.
- IDLE: frame_idx=0, char_y=GROUND_Y. If jump_req=1 on a frame tick, go to RISING with vy=JUMP_V0, hold counter=0. No other change to char_y on that tick.
- RISING tick:
  - char_y -= vy, then vy -= GRAVITY.
  - If the new vy is 0, go to FALLING.
- FALLING tick:
  - vy += GRAVITY.
  - If char_y+vy >= GROUND_Y, set char_y=GROUND_Y and go to LANDING with the land counter cleared.
  - Otherwise char_y += vy.
- LANDING: frame_idx = NUM_FRAMES-1. Go to IDLE after LAND_FRAMES ticks.
- Animation in RISING and FALLING: the hold counter counts frame ticks. Every FRAME_HOLD ticks, frame_idx increments, saturating at NUM_FRAMES-2.
- jump_req outside IDLE is ignored. Requests are not queued.
- Hitbox mapping, computed every cycle:
  - dx = DrawX - char_x and dy = DrawY - char_y, both 11-bit signed.
  - in_hitbox = (0 <= dx < HIT_W) && (0 <= dy < HIT_H).
  - sprite_x = facing_left ? HIT_W-1-dx : dx.
  - sprite_y = dy.
  - When in_hitbox=0, sprite_x and sprite_y are 0.
- Reset, including mid-jump: state IDLE, char_y=GROUND_Y, vy=0, frame_idx=0, counters 0, jumping=0, in_hitbox=0, sprite_x=0, sprite_y=0.

## Timing
- in_hitbox, sprite_x and sprite_y are registered. They appear 1 vga_clk after the DrawX/DrawY they describe, aligned with the renderer's negedge ROM read.
- char_y, frame_idx and jumping update 1 cycle after the frame_start pulse. The mapping uses the registered char_y, so position is stable for the whole visible frame.
- Jump profile with the defaults:
  - 12 RISING ticks; apex char_y=202.
  - 12 FALLING ticks back to 280.
  - 6 LANDING ticks.
  - Total 30 frame ticks from the first RISING tick to IDLE.
- frame_start and Reset in the same cycle: Reset wins.

## Structure
- jump_pkg holds the state enum (jump_state_t) and the default constants. These are shared with the renderer selection mux.
- One sub-module, hitbox_map, holds the registered coordinate subtraction, range check and mirroring. The top level holds the FSM and counters.

## Test plan
- Reset -> char_y=280, frame_idx=0, jumping=0, in_hitbox=0 on the next cycle.
- jump_req=1 over 30 frame_start pulses:
  - char_y=202 after tick 12 and 280 after tick 24.
  - frame_idx=5 from tick 20.
  - frame_idx=6 during LANDING.
  - IDLE after tick 30.
- jump_req held without frame_start -> no state change. jump_req pulsed mid-jump -> trajectory unchanged, no re-trigger.
- char_x=100, char_y=280, facing_left=0:
  - DrawX=100/DrawY=280 -> next cycle in_hitbox=1, sprite_x=0, sprite_y=0.
  - DrawX=179 -> sprite_x=79.
  - DrawX=180 or 99 -> in_hitbox=0.
- facing_left=1, DrawX=100 -> sprite_x=79. DrawY=439 -> sprite_y=159. DrawY=440 -> in_hitbox=0.
- Reset asserted at RISING tick 7 -> next cycle char_y=280, IDLE, frame_idx=0. A new jump then proceeds normally.

Source files
------------

// File: rtl/jump_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jump_pkg
// Description : Shared jump state encoding, default jump/hitbox constants and
//               a small animation helper, used by the jump controller and the
//               renderer selection mux.
// Revision    : 1.0 - initial release
// ============================================================================
package jump_pkg;

    typedef enum logic [1:0] {
        JS_IDLE    = 2'd0,
        JS_RISING  = 2'd1,
        JS_FALLING = 2'd2,
        JS_LANDING = 2'd3
    } jump_state_t;

    localparam int DEF_HIT_W       = 80;
    localparam int DEF_HIT_H       = 160;
    localparam int DEF_GROUND_Y    = 280;
    localparam int DEF_JUMP_V0     = 12;
    localparam int DEF_GRAVITY     = 1;
    localparam int DEF_FRAME_HOLD  = 4;
    localparam int DEF_LAND_FRAMES = 6;
    localparam int DEF_NUM_FRAMES  = 7;

    // Width of the hold and landing tick counters (supports up to 16 ticks).
    localparam int CNT_W = 4;

    // Step an animation index by one, saturating at last.
    function automatic logic [2:0] anim_advance(input logic [2:0] cur,
                                                input logic [2:0] last);
        return (cur < last) ? (cur + 3'd1) : cur;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hitbox_map.sv
`default_nettype none
// ============================================================================
// Module      : hitbox_map
// Description : Converts the current screen pixel into hitbox-relative sprite
//               coordinates with optional horizontal mirroring. Outputs are
//               registered one pixel clock behind DrawX/DrawY.
// Revision    : 1.0 - initial release
// ============================================================================
module hitbox_map #(
    parameter int HIT_W = 80,
    parameter int HIT_H = 160
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       facing_left,
    input  logic [9:0] char_x,
    input  logic [9:0] char_y,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic       in_hitbox,
    output logic [6:0] sprite_x,
    output logic [7:0] sprite_y
);

    localparam logic signed [10:0] c_HIT_W  = 11'(HIT_W);
    localparam logic signed [10:0] c_HIT_H  = 11'(HIT_H);
    localparam logic [6:0]         c_X_LAST = 7'(HIT_W - 1);

    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic               w_inside;
    logic [6:0]         w_sx;

    logic               r_in_hitbox;
    logic [6:0]         r_sprite_x;
    logic [7:0]         r_sprite_y;

    // Zero-extend to 11 bits so the difference carries its sign.
    assign w_dx = $signed({1'b0, DrawX}) - $signed({1'b0, char_x});
    assign w_dy = $signed({1'b0, DrawY}) - $signed({1'b0, char_y});

    assign w_inside = (w_dx >= 11'sd0) && (w_dx < c_HIT_W) &&
                      (w_dy >= 11'sd0) && (w_dy < c_HIT_H);

    // Inside the hitbox dx fits in 7 bits, so the low bits suffice for the mirror.
    assign w_sx = facing_left ? (c_X_LAST - w_dx[6:0]) : w_dx[6:0];

    // Register the mapped coordinates; outside the hitbox they are forced to 0.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_in_hitbox <= 1'b0;
            r_sprite_x  <= '0;
            r_sprite_y  <= '0;
        end else begin
            r_in_hitbox <= w_inside;
            r_sprite_x  <= w_inside ? w_sx : '0;
            r_sprite_y  <= w_inside ? w_dy[7:0] : '0;
        end
    end

    assign in_hitbox = r_in_hitbox;
    assign sprite_x  = r_sprite_x;
    assign sprite_y  = r_sprite_y;

endmodule
`default_nettype wire

// File: rtl/jump_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : jump_motion_ctrl
// Description : Per-fighter jump sequencer. Advances the vertical trajectory
//               and animation index once per video frame and maps the current
//               pixel into hitbox-relative sprite coordinates every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module jump_motion_ctrl
    import jump_pkg::*;
#(
    parameter int HIT_W       = DEF_HIT_W,
    parameter int HIT_H       = DEF_HIT_H,
    parameter int GROUND_Y    = DEF_GROUND_Y,
    parameter int JUMP_V0     = DEF_JUMP_V0,
    parameter int GRAVITY     = DEF_GRAVITY,
    parameter int FRAME_HOLD  = DEF_FRAME_HOLD,
    parameter int LAND_FRAMES = DEF_LAND_FRAMES,
    parameter int NUM_FRAMES  = DEF_NUM_FRAMES
) (
    input  logic       vga_clk,
    input  logic       Reset,
    input  logic       frame_start,
    input  logic       jump_req,
    input  logic       facing_left,
    input  logic [9:0] char_x,
    input  logic [9:0] DrawX,
    input  logic [9:0] DrawY,
    output logic [9:0] char_y,
    output logic [2:0] frame_idx,
    output logic       jumping,
    output logic       in_hitbox,
    output logic [6:0] sprite_x,
    output logic [7:0] sprite_y
);

    localparam logic [1:0] c_ST_IDLE    = JS_IDLE;
    localparam logic [1:0] c_ST_RISING  = JS_RISING;
    localparam logic [1:0] c_ST_FALLING = JS_FALLING;
    localparam logic [1:0] c_ST_LANDING = JS_LANDING;

    localparam logic [9:0]       c_GROUND_Y   = 10'(GROUND_Y);
    localparam logic [4:0]       c_V0         = 5'(JUMP_V0);
    localparam logic [4:0]       c_GRAV       = 5'(GRAVITY);
    localparam logic [CNT_W-1:0] c_HOLD_LAST  = CNT_W'(FRAME_HOLD - 1);
    localparam logic [CNT_W-1:0] c_LAND_LAST  = CNT_W'(LAND_FRAMES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]       c_AIR_LAST   = 3'(NUM_FRAMES - 2);
    localparam logic [2:0]       c_LAND_FRAME = 3'(NUM_FRAMES - 1);

    logic [1:0]       r_state;
    logic [4:0]       r_vy;
    logic [9:0]       r_char_y;
    logic [2:0]       r_frame_idx;
    logic [CNT_W-1:0] r_hold;
    logic [CNT_W-1:0] r_land;

    logic [4:0]       w_vy_down;
    logic [4:0]       w_vy_up;
    logic [10:0]      w_fall_sum;
    logic             w_hold_wrap;
    logic [CNT_W-1:0] w_hold_next;
    logic [2:0]       w_frame_next;

    assign w_vy_down  = r_vy - c_GRAV;
    assign w_vy_up    = r_vy + c_GRAV;
    // One extra bit so the landing comparison cannot wrap.
    assign w_fall_sum = {1'b0, r_char_y} + {6'b0, w_vy_up};

    // Airborne animation: step the frame every FRAME_HOLD ticks.
    assign w_hold_wrap  = (r_hold == c_HOLD_LAST);
    assign w_hold_next  = w_hold_wrap ? '0 : (r_hold + c_CNT_ONE);
    assign w_frame_next = w_hold_wrap ? anim_advance(r_frame_idx, c_AIR_LAST)
                                      : r_frame_idx;

    // Jump FSM and trajectory; everything advances only on frame ticks.
    always_ff @(posedge vga_clk) begin
        if (Reset) begin
            r_state     <= c_ST_IDLE;
            r_vy        <= '0;
            r_char_y    <= c_GROUND_Y;
            r_frame_idx <= '0;
            r_hold      <= '0;
            r_land      <= '0;
        end else if (frame_start) begin
            case (r_state)
                c_ST_IDLE: begin
                    r_char_y    <= c_GROUND_Y;
                    r_frame_idx <= '0;
                    if (jump_req) begin
                        r_state <= c_ST_RISING;
                        r_vy    <= c_V0;
                        r_hold  <= '0;
                    end
                end
                c_ST_RISING: begin
                    r_char_y    <= r_char_y - {5'b0, r_vy};
                    r_vy        <= w_vy_down;
                    r_hold      <= w_hold_next;
                    r_frame_idx <= w_frame_next;
                    if (w_vy_down == '0) begin
                        r_state <= c_ST_FALLING;
                    end
                end
                c_ST_FALLING: begin
                    r_vy <= w_vy_up;
                    if (w_fall_sum >= {1'b0, c_GROUND_Y}) begin
                        r_char_y    <= c_GROUND_Y;
                        r_state     <= c_ST_LANDING;
                        r_land      <= '0;
                        r_frame_idx <= c_LAND_FRAME;
                    end else begin
                        r_char_y    <= w_fall_sum[9:0];
                        r_hold      <= w_hold_next;
                        r_frame_idx <= w_frame_next;
                    end
                end
                c_ST_LANDING: begin
                    if (r_land == c_LAND_LAST) begin
                        r_state     <= c_ST_IDLE;
                        r_frame_idx <= '0;
                        r_land      <= '0;
                        r_vy        <= '0;
                    end else begin
                        r_frame_idx <= c_LAND_FRAME;
                        r_land      <= r_land + c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign char_y    = r_char_y;
    assign frame_idx = r_frame_idx;
    assign jumping   = (r_state != c_ST_IDLE);

    // Pixel-to-sprite mapping uses the registered position, stable all frame.
    hitbox_map #(
        .HIT_W (HIT_W),
        .HIT_H (HIT_H)
    ) u_hitbox_map (
        .vga_clk     (vga_clk),
        .Reset       (Reset),
        .facing_left (facing_left),
        .char_x      (char_x),
        .char_y      (r_char_y),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .in_hitbox   (in_hitbox),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y)
    );

endmodule
`default_nettype wire

// File: tb/tb_jump_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_jump_motion_ctrl
// Description : Self-checking bench for jump_motion_ctrl: hitbox vector table,
//               hand-written jump sequences and randomized traffic against a
//               closed-form trajectory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jump_motion_ctrl;

    localparam int HIT_W    = 80;
    localparam int HIT_H    = 160;
    localparam int GROUND_Y = 280;
    localparam int JUMP_LEN = 30;   // frame ticks from first RISING tick to IDLE

    logic       vga_clk = 1'b0;
    logic       Reset = 1'b1;
    logic       frame_start = 1'b0;
    logic       jump_req = 1'b0;
    logic       facing_left = 1'b0;
    logic [9:0] char_x = 10'd100;
    logic [9:0] DrawX = 10'd0;
    logic [9:0] DrawY = 10'd0;
    logic [9:0] char_y;
    logic [2:0] frame_idx;
    logic       jumping;
    logic       in_hitbox;
    logic [6:0] sprite_x;
    logic [7:0] sprite_y;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: -1 when idle, otherwise number of frame ticks since the trigger tick.
    int m_age = -1;
    int m_in  = 0;
    int m_sx  = 0;
    int m_sy  = 0;

    typedef struct {
        logic [9:0] cx;
        logic [9:0] dx;
        logic [9:0] dy;
        logic       fl;
        logic       e_in;
        logic [6:0] e_sx;
        logic [7:0] e_sy;
    } hb_vec_t;

    hb_vec_t vecs [13];

    jump_motion_ctrl dut (
        .vga_clk     (vga_clk),
        .Reset       (Reset),
        .frame_start (frame_start),
        .jump_req    (jump_req),
        .facing_left (facing_left),
        .char_x      (char_x),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .char_y      (char_y),
        .frame_idx   (frame_idx),
        .jumping     (jumping),
        .in_hitbox   (in_hitbox),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y)
    );

    always #5 vga_clk = ~vga_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Height after a ticks of a jump: ballistic rise of 12+11+...,
    // then fall of 1+2+... from the apex, clamped at the ground.
    function automatic int prof_y(input int a);
        int j;
        if (a <= 12) return GROUND_Y - (12 * a - (a * (a - 1)) / 2);
        if (a <= 24) begin
            j = a - 12;
            return (202 + (j * (j + 1)) / 2 > GROUND_Y) ? GROUND_Y : 202 + (j * (j + 1)) / 2;
        end
        return GROUND_Y;
    endfunction

    function automatic int prof_frame(input int a);
        if (a >= 24) return 6;
        return (a / 4 > 5) ? 5 : a / 4;
    endfunction

    function automatic int model_y();
        return (m_age < 0) ? GROUND_Y : prof_y(m_age);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model with the inputs sampled at this edge, then compare.
    task automatic cycle();
        int cy;
        int dx;
        int dy;
        @(posedge vga_clk);
        #1;
        cy = model_y();
        dx = int'(DrawX) - int'(char_x);
        dy = int'(DrawY) - cy;
        if (Reset) begin
            m_in = 0; m_sx = 0; m_sy = 0;
            m_age = -1;
        end else begin
            m_in = (dx >= 0 && dx < HIT_W && dy >= 0 && dy < HIT_H) ? 1 : 0;
            m_sx = m_in ? (facing_left ? HIT_W - 1 - dx : dx) : 0;
            m_sy = m_in ? dy : 0;
            if (frame_start) begin
                if (m_age < 0) begin
                    if (jump_req) m_age = 0;
                end else begin
                    m_age++;
                    if (m_age >= JUMP_LEN) m_age = -1;
                end
            end
        end
        check("char_y",    int'(char_y),    model_y());
        check("frame_idx", int'(frame_idx), (m_age < 0) ? 0 : prof_frame(m_age));
        check("jumping",   int'(jumping),   (m_age >= 0) ? 1 : 0);
        check("in_hitbox", int'(in_hitbox), m_in);
        check("sprite_x",  int'(sprite_x),  m_sx);
        check("sprite_y",  int'(sprite_y),  m_sy);
    endtask

    task automatic frame_tick(input logic jr);
        frame_start = 1'b1;
        jump_req    = jr;
        cycle();
        frame_start = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        vecs[0]  = '{10'd100, 10'd100, 10'd280, 1'b0, 1'b1, 7'd0,  8'd0};
        vecs[1]  = '{10'd100, 10'd179, 10'd280, 1'b0, 1'b1, 7'd79, 8'd0};
        vecs[2]  = '{10'd100, 10'd180, 10'd280, 1'b0, 1'b0, 7'd0,  8'd0};
        vecs[3]  = '{10'd100, 10'd99,  10'd280, 1'b0, 1'b0, 7'd0,  8'd0};
        vecs[4]  = '{10'd100, 10'd100, 10'd280, 1'b1, 1'b1, 7'd79, 8'd0};
        vecs[5]  = '{10'd100, 10'd100, 10'd439, 1'b1, 1'b1, 7'd79, 8'd159};
        vecs[6]  = '{10'd100, 10'd100, 10'd440, 1'b1, 1'b0, 7'd0,  8'd0};
        vecs[7]  = '{10'd100, 10'd179, 10'd439, 1'b1, 1'b1, 7'd0,  8'd159};
        vecs[8]  = '{10'd100, 10'd150, 10'd300, 1'b0, 1'b1, 7'd50, 8'd20};
        vecs[9]  = '{10'd100, 10'd150, 10'd300, 1'b1, 1'b1, 7'd29, 8'd20};
        vecs[10] = '{10'd100, 10'd100, 10'd279, 1'b0, 1'b0, 7'd0,  8'd0};
        vecs[11] = '{10'd0,   10'd0,   10'd280, 1'b0, 1'b1, 7'd0,  8'd0};
        vecs[12] = '{10'd900, 10'd10,  10'd300, 1'b0, 1'b0, 7'd0,  8'd0};

        // Reset state
        Reset = 1'b1;
        cycle();
        check("rst_char_y",  int'(char_y),    GROUND_Y);
        check("rst_frame",   int'(frame_idx), 0);
        check("rst_jumping", int'(jumping),   0);
        check("rst_in_hit",  int'(in_hitbox), 0);
        Reset = 1'b0;
        cycle();

        // Held jump request with no frame tick does nothing
        jump_req = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        check("noframe_jumping", int'(jumping), 0);
        check("noframe_char_y",  int'(char_y),  GROUND_Y);
        jump_req = 1'b0;
        cycle();

        // Hitbox vector table while standing on the ground
        for (int i = 0; i < 13; i++) begin
            char_x      = vecs[i].cx;
            DrawX       = vecs[i].dx;
            DrawY       = vecs[i].dy;
            facing_left = vecs[i].fl;
            cycle();
            check($sformatf("vec%0d_in", i), int'(in_hitbox), int'(vecs[i].e_in));
            check($sformatf("vec%0d_sx", i), int'(sprite_x),  int'(vecs[i].e_sx));
            check($sformatf("vec%0d_sy", i), int'(sprite_y),  int'(vecs[i].e_sy));
        end

        // Full jump with the request held throughout
        frame_tick(1'b1);
        check("trig_jumping", int'(jumping), 1);
        check("trig_char_y",  int'(char_y),  GROUND_Y);
        for (int t = 1; t <= JUMP_LEN; t++) begin
            frame_tick(1'b1);
            if (t == 12) check("apex_char_y", int'(char_y), 202);
            if (t == 20) check("t20_frame",   int'(frame_idx), 5);
            if (t == 24) check("t24_char_y",  int'(char_y), GROUND_Y);
            if (t == 25) check("land_frame",  int'(frame_idx), 6);
            if (t == 29) check("t29_jumping", int'(jumping), 1);
            if (t == JUMP_LEN) check("t30_jumping", int'(jumping), 0);
        end
        jump_req = 1'b0;
        cycle();

        // Request pulsed mid-jump must not disturb or re-trigger
        frame_tick(1'b1);
        for (int t = 1; t <= JUMP_LEN + 2; t++) begin
            frame_tick((t == 5 || t == 26) ? 1'b1 : 1'b0);
            if (t == 12) check("pulse_apex", int'(char_y), 202);
            if (t == JUMP_LEN + 2) check("pulse_idle", int'(jumping), 0);
        end

        // Reset coinciding with a rising frame tick wins, then a fresh jump
        frame_tick(1'b1);
        for (int t = 1; t <= 6; t++) frame_tick(1'b0);
        Reset = 1'b1;
        frame_tick(1'b0);
        Reset = 1'b0;
        check("midrst_char_y",  int'(char_y),    GROUND_Y);
        check("midrst_jumping", int'(jumping),   0);
        check("midrst_frame",   int'(frame_idx), 0);
        frame_tick(1'b1);
        for (int t = 1; t <= JUMP_LEN; t++) begin
            frame_tick(1'b0);
            if (t == 12) check("rejump_apex", int'(char_y), 202);
        end
        check("rejump_idle", int'(jumping), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            Reset       = ($urandom_range(0, 199) == 0);
            frame_start = ($urandom_range(0, 2) == 0);
            jump_req    = ($urandom_range(0, 3) != 0);
            facing_left = 1'($urandom_range(0, 1));
            char_x      = 10'($urandom_range(0, 900));
            DrawX       = 10'(int'(char_x) + int'($urandom_range(0, 120)) - 20);
            DrawY       = 10'($urandom_range(170, 470));
            cycle();
        end
        Reset = 1'b0;
        frame_start = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
